// File: rtl/decode_ctrl.sv
// decode_ctrl: multi-cycle decode and sequencing controller for the RV32
// integer ALU subset (OP and OP-IMM). One instruction is accepted through a
// valid/ready handshake, its sources are read from the register file, the ALU
// is driven with registered operands and the result is written back.
// Optional feature macro: DECODE_PERF_CNT_EN adds cycle_count/retire_count.
module decode_ctrl #(
   parameter int XLEN  = 32,
   parameter int RF_AW = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [31:0]      instr_data,
   output logic             instr_ready,
   output logic [3:0]       alu_opcode,
   output logic [XLEN-1:0]  alu_op_a,
   output logic [XLEN-1:0]  alu_op_b,
   input  logic [XLEN-1:0]  alu_result,
   output logic             rf_ce,
   output logic [RF_AW-1:0] rf_rs1_addr,
   output logic [RF_AW-1:0] rf_rs2_addr,
   input  logic [XLEN-1:0]  rf_rs1_data,
   input  logic [XLEN-1:0]  rf_rs2_data,
   output logic             rf_we,
   output logic [RF_AW-1:0] rf_wr_addr,
   output logic [XLEN-1:0]  rf_wr_data,
   output logic             illegal
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [31:0]      cycle_count,
   output logic [31:0]      retire_count
`endif
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SRA  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_READ   = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4
   } state_t;

   // Zero-extend a 5-bit instruction register field to the register-file address width.
   function automatic logic [RF_AW-1:0] zext_addr(input logic [4:0] field);
      logic [RF_AW-1:0] r;
      r      = '0;
      r[4:0] = field;
      return r;
   endfunction

   // Returns {illegal, alu_code}. funct3 selects the base operation; funct7
   // only distinguishes SUB/SRA(I) and otherwise must be zero. OP-IMM with
   // funct3=000 never looks at funct7, so ADDI cannot turn into SUB.
   function automatic logic [4:0] decode_fn(input logic [6:0] opc,
                                            input logic [2:0] f3,
                                            input logic [6:0] f7);
      logic       ill;
      logic [3:0] op;
      ill = 1'b0;
      op  = ALU_ADD;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      if (opc == OPC_OP) begin
         if (f7 == F7_ALT) begin
            if (f3 == 3'b000)      op  = ALU_SUB;
            else if (f3 == 3'b101) op  = ALU_SRA;
            else                   ill = 1'b1;
         end else if (f7 != F7_BASE) begin
            ill = 1'b1;
         end
      end else if (opc == OPC_OP_IMM) begin
         if (f3 == 3'b001) begin
            if (f7 != F7_BASE) ill = 1'b1;
         end else if (f3 == 3'b101) begin
            if (f7 == F7_ALT)        op  = ALU_SRA;
            else if (f7 != F7_BASE)  ill = 1'b1;
         end
      end else begin
         ill = 1'b1;
      end
      return {ill, op};
   endfunction

   state_t            state_q, state_d;
   logic [6:0]        opc_q;
   logic [2:0]        f3_q;
   logic [11:0]       imm_q;
   logic [4:0]        rd_q;
   logic [RF_AW-1:0]  rs1_addr_q, rs2_addr_q, wr_addr_q;
   logic [3:0]        alu_opcode_q;
   logic [XLEN-1:0]   op_a_q, op_b_q, wb_data_q;

   logic              accept;
   logic              dec_ill;
   logic [3:0]        dec_op;
   logic              is_rtype;
   logic              is_shift_imm;
   logic [XLEN-1:0]   imm_ext, shamt_ext, op_b_d;

   assign accept = instr_valid && instr_ready;

   // Decode of the latched instruction fields and selection of operand B.
   always_comb begin
      {dec_ill, dec_op} = decode_fn(opc_q, f3_q, imm_q[11:5]);
      is_rtype          = (opc_q == OPC_OP);
      is_shift_imm      = (f3_q == 3'b001) || (f3_q == 3'b101);
      imm_ext           = {{(XLEN-12){imm_q[11]}}, imm_q};
      shamt_ext         = '0;
      shamt_ext[4:0]    = imm_q[4:0];
      if (is_rtype)          op_b_d = rf_rs2_data;
      else if (is_shift_imm) op_b_d = shamt_ext;
      else                   op_b_d = imm_ext;
   end

   // State register; reset returns to IDLE from any state.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic: fixed five-step sequence, illegal instructions exit from DECODE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_DECODE;
         S_DECODE: state_d = dec_ill ? S_IDLE : S_READ;
         S_READ:   state_d = S_EXEC;
         S_EXEC:   state_d = S_WB;
         S_WB:     state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Control outputs decoded from the current state.
   always_comb begin
      instr_ready = (state_q == S_IDLE);
      rf_ce       = (state_q == S_DECODE);
      illegal     = (state_q == S_DECODE) && dec_ill;
      rf_we       = (state_q == S_WB) && (rd_q != 5'd0);
   end

   // Instruction field, operand and write-back registers; each holds until its load step.
   always_ff @(posedge clk) begin
      if (!rst) begin
         opc_q        <= '0;
         f3_q         <= '0;
         imm_q        <= '0;
         rd_q         <= '0;
         rs1_addr_q   <= '0;
         rs2_addr_q   <= '0;
         wr_addr_q    <= '0;
         alu_opcode_q <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         wb_data_q    <= '0;
      end else begin
         // Source addresses load on the accept edge so the RF sees them throughout DECODE.
         if (accept) begin
            opc_q      <= instr_data[6:0];
            f3_q       <= instr_data[14:12];
            imm_q      <= instr_data[31:20];
            rd_q       <= instr_data[11:7];
            rs1_addr_q <= zext_addr(instr_data[19:15]);
            if (instr_data[6:0] == OPC_OP)
               rs2_addr_q <= zext_addr(instr_data[24:20]);
         end
         if (state_q == S_READ) begin
            alu_opcode_q <= dec_op;
            op_a_q       <= rf_rs1_data;
            op_b_q       <= op_b_d;
         end
         if (state_q == S_EXEC) begin
            wb_data_q <= alu_result;
            wr_addr_q <= zext_addr(rd_q);
         end
      end
   end

   assign alu_opcode  = alu_opcode_q;
   assign alu_op_a    = op_a_q;
   assign alu_op_b    = op_b_q;
   assign rf_rs1_addr = rs1_addr_q;
   assign rf_rs2_addr = rs2_addr_q;
   assign rf_wr_addr  = wr_addr_q;
   assign rf_wr_data  = wb_data_q;

`ifdef DECODE_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, retire_cnt_q;

   // Free-running cycle counter and retired-instruction counter (x0 writes included).
   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (state_q == S_WB) retire_cnt_q <= retire_cnt_q + 32'd1;
      end
   end

   assign cycle_count  = cycle_cnt_q;
   assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl with a behavioural register file,
// a behavioural ALU and an instruction-level reference model.
module tb_decode_ctrl;
   localparam int XLEN  = 32;
   localparam int RF_AW = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             instr_valid;
   logic [31:0]      instr_data;
   logic             instr_ready;
   logic [3:0]       alu_opcode;
   logic [XLEN-1:0]  alu_op_a, alu_op_b, alu_result;
   logic             rf_ce;
   logic [RF_AW-1:0] rf_rs1_addr, rf_rs2_addr, rf_wr_addr;
   logic [XLEN-1:0]  rf_rs1_data, rf_rs2_data, rf_wr_data;
   logic             rf_we;
   logic             illegal;
`ifdef DECODE_PERF_CNT_EN
   logic [31:0]      cycle_count, retire_count;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] rf    [32];
   logic [31:0] mregs [32];
   logic        pl_en = 1'b0;
   logic [4:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   always #5 clk = ~clk;

   decode_ctrl #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
      .alu_opcode(alu_opcode), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_result(alu_result),
      .rf_ce(rf_ce), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .illegal(illegal)
`ifdef DECODE_PERF_CNT_EN
      , .cycle_count(cycle_count), .retire_count(retire_count)
`endif
   );

   // ALU semantics by operation code
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << b[4:0];
         4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd7: return (a < b) ? 32'd1 : 32'd0;
         4'd8: return $signed(a) >>> b[4:0];
         4'd9: return a >> b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   always_comb alu_result = ref_alu(alu_opcode, alu_op_a, alu_op_b);

   // Synchronous-read register file; preload port used only while the DUT is idle
   always @(posedge clk) begin
      if (pl_en) rf[pl_addr] <= pl_data;
      else if (rf_we) rf[rf_wr_addr] <= rf_wr_data;
      if (rf_ce) begin
         rf_rs1_data <= rf[rf_rs1_addr];
         rf_rs2_data <= rf[rf_rs2_addr];
      end
   end

   // Instruction-level reference: legality, ALU code and operands from the ISA rules
   function automatic void model(input logic [31:0] ins, output logic ill, output logic is_r,
                                 output logic [3:0] op, output logic [31:0] a, output logic [31:0] b);
      logic [6:0] opc, f7;
      logic [2:0] f3;
      logic       is_i, alt;
      opc  = ins[6:0];
      f3   = ins[14:12];
      f7   = ins[31:25];
      is_r = (opc == 7'h33);
      is_i = (opc == 7'h13);
      alt  = (f7 == 7'h20);
      if (is_r)      ill = !((f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5)));
      else if (is_i) ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 == 7'h00 || alt));
      else           ill = 1'b1;
      case (f3)
         3'd0: op = 4'd0;  3'd1: op = 4'd5;  3'd2: op = 4'd6;  3'd3: op = 4'd7;
         3'd4: op = 4'd4;  3'd5: op = 4'd9;  3'd6: op = 4'd3;  default: op = 4'd2;
      endcase
      if (alt && f3 == 3'd5) op = 4'd8;
      if (is_r && alt && f3 == 3'd0) op = 4'd1;
      a = mregs[ins[19:15]];
      if (is_r)                         b = mregs[ins[24:20]];
      else if (f3 == 3'd1 || f3 == 3'd5) b = {27'd0, ins[24:20]};
      else                              b = {{20{ins[31]}}, ins[31:20]};
   endfunction

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
      mregs[a] = d;
   endtask

   // Issues one instruction and follows it cycle by cycle against the reference
   task automatic do_instr(input logic [31:0] ins, output logic [31:0] wd,
                           output logic [3:0] op_o, output logic [31:0] opb_o);
      logic ill, is_r;
      logic [3:0] eop;
      logic [31:0] ea, eb, eres, prev_a;
      logic [4:0] rd;
      int n;
      model(ins, ill, is_r, eop, ea, eb);
      eres = ref_alu(eop, ea, eb);
      rd = ins[11:7];
      wd = '0; op_o = alu_opcode; opb_o = alu_op_b;
      n = 0;
      while (instr_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL ready_wait got=%0b exp=1", instr_ready); return; end
      prev_a = alu_op_a;
      instr_valid = 1'b1; instr_data = ins;
      @(posedge clk); #1;
      instr_valid = 1'b0; instr_data = $urandom;
      checks++; if (illegal !== ill) begin failures++; $display("FAIL illegal_c1 ins=%h got=%0b exp=%0b", ins, illegal, ill); end
      checks++; if (rf_rs1_addr !== ins[19:15]) begin failures++; $display("FAIL rs1_addr ins=%h got=%0d exp=%0d", ins, rf_rs1_addr, ins[19:15]); end
      if (is_r) begin
         checks++; if (rf_rs2_addr !== ins[24:20]) begin failures++; $display("FAIL rs2_addr ins=%h got=%0d exp=%0d", ins, rf_rs2_addr, ins[24:20]); end
      end
      checks++; if (rf_ce !== 1'b1) begin failures++; $display("FAIL rf_ce_c1 got=%0b exp=1", rf_ce); end
      checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL ready_c1 got=%0b exp=0", instr_ready); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL we_c1 got=%0b exp=0", rf_we); end
      if (ill) begin
         @(posedge clk); #1;
         checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL ill_ready_c2 ins=%h got=%0b exp=1", ins, instr_ready); end
         checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL ill_pulse_c2 got=%0b exp=0", illegal); end
         checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL ill_we got=%0b exp=0", rf_we); end
         checks++; if (alu_op_a !== prev_a) begin failures++; $display("FAIL ill_opa_hold got=%h exp=%h", alu_op_a, prev_a); end
         return;
      end
      @(posedge clk); #1;
      checks++; if (instr_ready !== 1'b0 || rf_we !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL ctrl_c2 got=%0b%0b%0b exp=000", instr_ready, rf_we, illegal); end
      @(posedge clk); #1;
      checks++; if (alu_opcode !== eop) begin failures++; $display("FAIL alu_opcode ins=%h got=%0d exp=%0d", ins, alu_opcode, eop); end
      checks++; if (alu_op_a !== ea) begin failures++; $display("FAIL alu_op_a ins=%h got=%h exp=%h", ins, alu_op_a, ea); end
      checks++; if (alu_op_b !== eb) begin failures++; $display("FAIL alu_op_b ins=%h got=%h exp=%h", ins, alu_op_b, eb); end
      checks++; if (rf_ce !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL ctrl_c3 got=%0b%0b exp=00", rf_ce, rf_we); end
      @(posedge clk); #1;
      checks++; if (rf_we !== (rd != 5'd0)) begin failures++; $display("FAIL we_c4 ins=%h got=%0b exp=%0b", ins, rf_we, (rd != 5'd0)); end
      if (rd != 5'd0) begin
         checks++; if (rf_wr_addr !== rd) begin failures++; $display("FAIL wr_addr got=%0d exp=%0d", rf_wr_addr, rd); end
         checks++; if (rf_wr_data !== eres) begin failures++; $display("FAIL wr_data ins=%h got=%h exp=%h", ins, rf_wr_data, eres); end
         mregs[rd] = eres;
      end
      wd = rf_wr_data; op_o = alu_opcode; opb_o = alu_op_b;
      @(posedge clk); #1;
      checks++; if (instr_ready !== 1'b1 || rf_we !== 1'b0) begin failures++; $display("FAIL ctrl_c5 got=%0b%0b exp=10", instr_ready, rf_we); end
   endtask

   task automatic test_reset();
      instr_valid = 1'b1; instr_data = 32'h002081B3; rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (instr_ready !== 1'b1 || rf_ce !== 1'b0 || rf_we !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL rst_ctrl got=%0b%0b%0b%0b exp=1000", instr_ready, rf_ce, rf_we, illegal); end
      checks++; if (alu_opcode !== 4'd0 || alu_op_a !== '0 || alu_op_b !== '0) begin failures++; $display("FAIL rst_alu got=%h/%h/%h exp=0", alu_opcode, alu_op_a, alu_op_b); end
      checks++; if (rf_rs1_addr !== '0 || rf_rs2_addr !== '0 || rf_wr_addr !== '0 || rf_wr_data !== '0) begin failures++; $display("FAIL rst_rf got=%0d/%0d/%0d/%h exp=0", rf_rs1_addr, rf_rs2_addr, rf_wr_addr, rf_wr_data); end
`ifdef DECODE_PERF_CNT_EN
      checks++; if (cycle_count !== 32'd0 || retire_count !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0", cycle_count, retire_count); end
`endif
      instr_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (instr_ready !== 1'b1 || rf_ce !== 1'b0) begin failures++; $display("FAIL rst_release got=%0b%0b exp=10", instr_ready, rf_ce); end
   endtask

   task automatic test_add();
      logic [31:0] wd, ob; logic [3:0] op;
      preload(5'd1, 32'd5); preload(5'd2, 32'd7);
      do_instr(32'h002081B3, wd, op, ob);
      checks++; if (wd !== 32'd12) begin failures++; $display("FAIL add_result got=%0d exp=12", wd); end
   endtask

   task automatic test_addi();
      logic [31:0] wd, ob; logic [3:0] op;
      do_instr(32'hFFF08213, wd, op, ob);
      checks++; if (op !== 4'd0 || ob !== 32'hFFFFFFFF || wd !== 32'd4) begin failures++; $display("FAIL addi got=%0d/%h/%0d exp=0/ffffffff/4", op, ob, wd); end
   endtask

   task automatic test_shift();
      logic [31:0] wd, ob; logic [3:0] op;
      preload(5'd1, 32'h80000000); preload(5'd2, 32'd4);
      do_instr(32'h4020D2B3, wd, op, ob);
      checks++; if (op !== 4'd8 || wd !== 32'hF8000000) begin failures++; $display("FAIL sra got=%0d/%h exp=8/f8000000", op, wd); end
      do_instr(32'h0040D293, wd, op, ob);
      checks++; if (op !== 4'd9 || wd !== 32'h08000000) begin failures++; $display("FAIL srli got=%0d/%h exp=9/08000000", op, wd); end
      do_instr(32'h4040D293, wd, op, ob);
      checks++; if (op !== 4'd8 || wd !== 32'hF8000000) begin failures++; $display("FAIL srai got=%0d/%h exp=8/f8000000", op, wd); end
   endtask

   task automatic test_x0();
      logic [31:0] wd, ob; logic [3:0] op;
`ifdef DECODE_PERF_CNT_EN
      logic [31:0] r0;
      r0 = retire_count;
`endif
      do_instr(32'h00208033, wd, op, ob);
`ifdef DECODE_PERF_CNT_EN
      checks++; if (retire_count !== r0 + 32'd1) begin failures++; $display("FAIL x0_retire got=%0d exp=%0d", retire_count, r0 + 32'd1); end
`endif
      checks++; if (rf[0] !== 32'd0) begin failures++; $display("FAIL x0_value got=%h exp=0", rf[0]); end
   endtask

   task automatic test_illegal();
      logic [31:0] wd, ob; logic [3:0] op;
      do_instr(32'h0000007F, wd, op, ob);
      do_instr(32'h4020F1B3, wd, op, ob);
      do_instr(32'h02009093, wd, op, ob);
      do_instr(32'h2000D293, wd, op, ob);
   endtask

   task automatic test_back_to_back();
      logic [31:0] wd, ob; logic [3:0] op;
      preload(5'd1, 32'd3); preload(5'd2, 32'd4);
      do_instr(32'h002083B3, wd, op, ob);
      do_instr(32'h00738433, wd, op, ob);
      checks++; if (wd !== 32'd14) begin failures++; $display("FAIL raw_result got=%0d exp=14", wd); end
   endtask

   task automatic test_random();
      logic [31:0] ins, wd, ob; logic [3:0] op;
      logic [2:0] f3; logic [6:0] f7; int kind;
      for (int i = 1; i < 32; i++) preload(i[4:0], $urandom);
      for (int k = 0; k < 60; k++) begin
         kind = $urandom_range(0, 9);
         f3 = 3'($urandom_range(0, 7));
         ins = $urandom;
         if (kind < 4) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            ins = {f7, ins[24:15], f3, ins[11:7], 7'h33};
         end else if (kind < 8) begin
            if (f3 == 3'd1) ins[31:25] = 7'h00;
            if (f3 == 3'd5) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            ins = {ins[31:15], f3, ins[11:7], 7'h13};
         end else if (kind == 8) begin
            ins = {7'h20, ins[24:15], f3, ins[11:7], 7'h33};
         end
         do_instr(ins, wd, op, ob);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 32; i++) begin
         checks++; if (rf[i] !== mregs[i]) begin failures++; $display("FAIL rf_final x%0d got=%h exp=%h", i, rf[i], mregs[i]); end
      end
   endtask

   task automatic test_reset_abort();
      int n;
      preload(5'd1, 32'd5); preload(5'd2, 32'd7); preload(5'd6, 32'hA5A5A5A5);
      n = 0;
      while (instr_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      instr_valid = 1'b1; instr_data = 32'h00208333;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (rf_we !== 1'b0 || illegal !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL abort_ctrl got=%0b%0b%0b exp=001", rf_we, illegal, instr_ready); end
      checks++; if (rf_wr_data !== '0 || alu_op_a !== '0) begin failures++; $display("FAIL abort_data got=%h/%h exp=0", rf_wr_data, alu_op_a); end
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         checks++; if (rf_we !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL abort_after got=%0b%0b exp=00", rf_we, illegal); end
      end
      checks++; if (rf[6] !== mregs[6]) begin failures++; $display("FAIL abort_x6 got=%h exp=%h", rf[6], mregs[6]); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_valid = 1'b0;
      instr_data  = '0;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      test_reset();
      preload(5'd0, 32'd0);
      test_add();
      test_addi();
      test_shift();
      test_x0();
      test_illegal();
      test_back_to_back();
      test_random();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Multi-cycle instruction decode and sequencing controller for the RV32 integer ALU subset (R-type OP and I-type OP-IMM). It accepts one 32-bit instruction through a valid/ready handshake and reads the source registers from the register file. It drives the ALU with a 4-bit operation code and XLEN-wide operands, then writes the result back. It sits between the fetch stage and the ALU/register file, replacing the fixed-width decoder. New behaviour:
- parametrised data and address widths;
- sign-extended immediates;
- correct SUB/SRA/SRAI discrimination;
- x0 write suppression;
- illegal-instruction reporting.

## Interface
- XLEN, 32, datapath width in bits; legal values ≥ 32.
- RF_AW, 5, register-file address width; legal values ≥ 5. Instruction fields are zero-extended to this width.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- instr_valid  input  1  fetch presents an instruction.
- instr_data  input  32  instruction word.
- instr_ready  output  1  block can accept an instruction.
- alu_opcode  output  4  ALU operation code.
- alu_op_a  output  XLEN  ALU operand A.
- alu_op_b  output  XLEN  ALU operand B.
- alu_result  input  XLEN  combinational ALU result.
- rf_ce  output  1  register-file chip enable.
- rf_rs1_addr  output  RF_AW  source address 1.
- rf_rs2_addr  output  RF_AW  source address 2.
- rf_rs1_data  input  XLEN  read data 1; valid one cycle after the address.
- rf_rs2_data  input  XLEN  read data 2; valid one cycle after the address.
- rf_we  output  1  write strobe, one-cycle pulse.
- rf_wr_addr  output  RF_AW  write address.
- rf_wr_data  output  XLEN  write data.
- illegal  output  1  one-cycle pulse: the instruction is unsupported.

## Operation
State machine: IDLE → DECODE → READ → EXEC → WB → IDLE.

- **IDLE**
  - instr_ready=1.
  - On instr_valid&&instr_ready: latch instr_data, drop instr_ready, go to DECODE.
- **DECODE**
  - Drive rf_rs1_addr=instr[19:15] and rf_ce=1.
  - Drive rf_rs2_addr=instr[24:20] for R-type; for I-type it is don't-care but holds its prior value.
  - Latch rd=instr[11:7] and compute alu_opcode.
  - If illegal: pulse illegal, go to IDLE with no write. Otherwise go to READ.
- **READ**
  - alu_op_a ← rf_rs1_data.
  - alu_op_b ← rf_rs2_data (R-type) or sign-extended instr[31:20] (I-type).
  - Shift-immediates use zero-extended instr[24:20].
- **EXEC**
  - Capture alu_result into the write-back register.
  - rf_ce=0.
- **WB**
  - rf_wr_addr=rd, rf_wr_data=captured result.
  - rf_we=1 for exactly one cycle, only if rd≠0.
  - Go to IDLE.

ALU code mapping:
- 0 ADD/ADDI; 1 SUB; 2 AND/ANDI; 3 OR/ORI; 4 XOR/XORI.
- 5 SLL/SLLI; 6 SLT/SLTI; 7 SLTU/SLTIU; 8 SRA/SRAI; 9 SRL/SRLI.

Instruction classes:
- R-type is opcode 0110011; I-type is opcode 0010011.
- R-type funct7 must be 0000000, or 0100000 only with funct3 000 (SUB) or 101 (SRA).
- I-type funct3 001 requires instr[31:25]=0000000.
- I-type funct3 101 requires instr[31:25]=0000000 (SRLI) or 0100000 (SRAI).
- ADDI never decodes as SUB.

Illegal instructions:
- Any other opcode, or any violation of the rules above, is illegal.
- An illegal instruction causes no register-file write and no ALU operand update.

Output hold and reset:
- alu_opcode, alu_op_a and alu_op_b hold their values until the next READ.
- rf_wr_addr and rf_wr_data hold until the next WB.
- Reset values: instr_ready=1; rf_ce=0; rf_we=0; illegal=0; every address, data, operand and opcode output 0; state=IDLE.

## Timing
- Accept edge is cycle 0:
  - DECODE in cycle 1;
  - READ in cycle 2;
  - EXEC in cycle 3;
  - rf_we high in cycle 4;
  - instr_ready high again in cycle 5.
- Throughput: one instruction per 5 cycles. An illegal instruction takes 2 cycles: illegal is high in cycle 1 and instr_ready is high in cycle 2.
- instr_valid is ignored while instr_ready=0. Fetch must hold instr_data stable only during the accept cycle.
- alu_result must settle within the EXEC cycle from alu_op_a, alu_op_b and alu_opcode registered at the end of READ.
- Reset wins over every state. Reset asserted mid-instruction aborts it at the next edge: no rf_we pulse and no illegal pulse follows.
- Back-to-back instructions: the second instruction's READ samples the register file after the first instruction's WB, so read-after-write needs no bypass.

## Configuration
- DECODE_PERF_CNT_EN defined:
  - adds output cycle_count[31:0], which increments every cycle while rst=1;
  - adds output retire_count[31:0], which increments on every WB, including rd=0;
  - both reset to 0, wrap at 2^32, and do not count illegal instructions as retired.
- Not defined: both ports and their counters are absent; all other behaviour is identical.

## Test plan
- Reset: hold rst=0 for 3 cycles with instr_valid=1 → instr_ready=1, rf_we=0, illegal=0, all outputs 0, nothing accepted.
- ADD x3,x1,x2 (0x002081B3) with x1=5, x2=7 →
  - cycle 1: rf_rs1_addr=1, rf_rs2_addr=2;
  - cycle 4: rf_we=1, rf_wr_addr=3, rf_wr_data=12;
  - cycle 5: instr_ready=1.
- ADDI x4,x1,-1 (0xFFF08213) with x1=5 → alu_opcode=0, alu_op_b=0xFFFFFFFF, write of 4 to x4.
- SRA/SRL with x1=0x80000000:
  - SRA x5,x1,x2 (0x4020D2B3), x2=4 → 0xF8000000, alu_opcode=8;
  - SRLI x5,x1,4 (0x0040D293) → 0x08000000, alu_opcode=9.
- ADD x0,x1,x2 (0x00208033) → no rf_we pulse; retire_count still +1 with DECODE_PERF_CNT_EN.
- Opcode 0x0000007F, then R-type funct7=0100000 with funct3=111 → each gives illegal high in cycle 1, no rf_we, instr_ready high in cycle 2. Then reset pulled low in the EXEC cycle of a valid ADD → no write occurs.
